// File: rtl/bus_interconnect.sv
// bus_interconnect: routes cpu memory requests by address region to slave 0
// (RAM), slave 1 (peripherals) or an internal error responder. Reads are
// tracked so that data comes back to the cpu in issue order.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   m_*                           cpu-side request / response
//   s0_*, s1_*                    slave-side request / response
//   unmapped_access               sticky flag, set by any accepted unmapped access
//
// The request and response paths are combinational. The only state is the
// outstanding-read count, the target those reads went to, the error-responder
// pulse and the sticky flag.
module bus_interconnect #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter logic [3:0]  S0_REGION       = 4'h1,
    parameter logic [3:0]  S1_REGION       = 4'h2
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic [31:0] m_addr,
    input  logic [31:0] m_write_data,
    input  logic [3:0]  m_byte_enable,
    input  logic        m_write_req,
    input  logic        m_read_req,
    output logic        m_ready,
    output logic [31:0] m_read_data,
    output logic        m_read_data_valid,

    output logic [31:0] s0_addr,
    output logic [31:0] s0_write_data,
    output logic [3:0]  s0_byte_enable,
    output logic        s0_write_req,
    output logic        s0_read_req,
    input  logic        s0_ready,
    input  logic [31:0] s0_read_data,
    input  logic        s0_read_data_valid,

    output logic [31:0] s1_addr,
    output logic [31:0] s1_write_data,
    output logic [3:0]  s1_byte_enable,
    output logic        s1_write_req,
    output logic        s1_read_req,
    input  logic        s1_ready,
    input  logic [31:0] s1_read_data,
    input  logic        s1_read_data_valid,

    output logic        unmapped_access
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned TGT_W = 2;

    localparam logic [TGT_W-1:0] TGT_S0  = 2'd0;
    localparam logic [TGT_W-1:0] TGT_S1  = 2'd1;
    localparam logic [TGT_W-1:0] TGT_ERR = 2'd2;

    logic [CNT_W-1:0] pending_count;
    logic [TGT_W-1:0] cur_target;
    logic             err_rsp_valid;

    logic [TGT_W-1:0] target;
    logic             sel_ready;
    logic             stall;
    logic             accept_rd;
    logic             accept_any;
    logic             ret_valid_raw;
    logic [31:0]      ret_data;
    logic             ret_valid;
    logic             pending_nz;
    logic             pending_full;

    // Address region decode
    always_comb begin
        target = TGT_ERR;
        if (m_addr[31:28] == S0_REGION) begin
            target = TGT_S0;
        end else if (m_addr[31:28] == S1_REGION) begin
            target = TGT_S1;
        end
    end

    // Return mux: only the slave the outstanding reads went to may answer
    always_comb begin
        ret_valid_raw = 1'b0;
        ret_data      = 32'h0;
        case (cur_target)
            TGT_S0: begin
                ret_valid_raw = s0_read_data_valid;
                ret_data      = s0_read_data;
            end
            TGT_S1: begin
                ret_valid_raw = s1_read_data_valid;
                ret_data      = s1_read_data;
            end
            default: begin
                ret_valid_raw = err_rsp_valid;
                ret_data      = 32'h0;
            end
        endcase
    end

    assign pending_nz   = (pending_count != '0);
    assign pending_full = (pending_count == CNT_W'(MAX_OUTSTANDING));

    // Returns with nothing outstanding (e.g. after reset) are dropped
    assign ret_valid         = ret_valid_raw && pending_nz;
    assign m_read_data_valid = ret_valid;
    assign m_read_data       = ret_valid ? ret_data : 32'h0;

    // A full tracker frees a slot in the same cycle a return arrives; a
    // target change waits for a fully drained tracker to keep return order.
    assign stall = m_read_req &&
                   ((pending_full && !ret_valid) ||
                    (pending_nz && (target != cur_target)));

    always_comb begin
        sel_ready = 1'b1;
        case (target)
            TGT_S0:  sel_ready = s0_ready;
            TGT_S1:  sel_ready = s1_ready;
            default: sel_ready = 1'b1;
        endcase
    end

    assign m_ready    = sel_ready && !stall;
    assign accept_rd  = m_read_req && m_ready;
    assign accept_any = (m_read_req || m_write_req) && m_ready;

    // Request forwarding
    assign s0_addr        = m_addr;
    assign s0_write_data  = m_write_data;
    assign s0_byte_enable = m_byte_enable;
    assign s0_write_req   = m_write_req && (target == TGT_S0) && !stall;
    assign s0_read_req    = m_read_req  && (target == TGT_S0) && !stall;

    assign s1_addr        = m_addr;
    assign s1_write_data  = m_write_data;
    assign s1_byte_enable = m_byte_enable;
    assign s1_write_req   = m_write_req && (target == TGT_S1) && !stall;
    assign s1_read_req    = m_read_req  && (target == TGT_S1) && !stall;

    // Outstanding-read tracking, error responder and sticky flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_count   <= '0;
            cur_target      <= TGT_S0;
            err_rsp_valid   <= 1'b0;
            unmapped_access <= 1'b0;
        end else begin
            if (accept_rd) begin
                cur_target <= target;
            end
            if (accept_rd && !ret_valid) begin
                pending_count <= pending_count + CNT_W'(1);
            end else if (!accept_rd && ret_valid) begin
                pending_count <= pending_count - CNT_W'(1);
            end
            err_rsp_valid <= accept_rd && (target == TGT_ERR);
            if (accept_any && (target == TGT_ERR)) begin
                unmapped_access <= 1'b1;
            end
        end
    end

endmodule
